// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
//
// Instruction fetch controller sitting between the PC register, a
// request/response instruction memory and the IF/ID pipeline register.
// One read is issued at a time. Returned data is handed to IF/ID together
// with the address it was fetched from. A hazard stall parks returned data
// in an internal buffer. A flush (taken branch/jump) marks any read still
// in flight as stale, so that its data is thrown away when it returns.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   pc_addr      current PC register value (32 bits)
//   stall_in     hazard stall: hold the fetched instruction, do not advance PC
//   flush        taken branch/jump; the PC mux already selects the target
//   mem_ready    instruction memory accepts the request this cycle
//   mem_rvalid   read data valid this cycle
//   mem_rdata    read data (32 bits)
//   pc_write     combinational enable to the PC register
//   mem_req      read request, combinational from state
//   mem_addr     read address, always equal to pc_addr
//   instr_out    registered instruction to IF/ID
//   instr_pc     registered fetch address of instr_out
//   instr_valid  registered one-cycle pulse per delivered instruction
// ---------------------------------------------------------------------------
module ifetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        pc_write,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  logic        discard;
  logic [31:0] addr_q;
  logic [31:0] hold_buf;

  // The memory always reads from the live PC value. The address may change
  // while a request is still waiting for mem_ready, e.g. after a flush.
  assign mem_addr = pc_addr;

  // Request and PC-advance enables. A flush always advances the PC, so the
  // branch target is loaded even while a stall is active. Otherwise the PC
  // only advances when an instruction is actually handed to IF/ID.
  always_comb begin
    mem_req  = 1'b0;
    pc_write = 1'b0;
    if (!reset) begin
      mem_req = (state == REQ);
      if (flush) begin
        pc_write = 1'b1;
      end else begin
        case (state)
          WAIT:    pc_write = mem_rvalid && !discard && !stall_in;
          HOLD:    pc_write = !stall_in;
          default: pc_write = 1'b0;
        endcase
      end
    end
  end

  // Fetch sequencing. mem_rvalid is only looked at in WAIT. This means a
  // response arriving in the acceptance cycle, or arriving after a reset
  // has pulled the FSM back to IDLE/REQ, is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      discard     <= 1'b0;
      addr_q      <= 32'd0;
      hold_buf    <= 32'd0;
      instr_out   <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          state <= REQ;
        end

        REQ: begin
          if (mem_ready) begin
            addr_q  <= pc_addr;
            // Accepted in the same cycle as a flush: this read is for the
            // old path, so its data must not be delivered.
            discard <= flush;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            discard <= 1'b0;
            state   <= REQ;
            if (!discard && !flush) begin
              if (stall_in) begin
                hold_buf <= mem_rdata;
                state    <= HOLD;
              end else begin
                instr_out   <= mem_rdata;
                instr_pc    <= addr_q;
                instr_valid <= 1'b1;
              end
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end

        HOLD: begin
          if (flush) begin
            state <= REQ;
          end else if (!stall_in) begin
            instr_out   <= hold_buf;
            instr_pc    <= addr_q;
            instr_valid <= 1'b1;
            state       <= REQ;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
